// File: rtl/gate_lab_tester.sv
// gate_lab_tester: sequential stimulus/response tester for the two-input gate
// lab block. Drives {a,b} = 00,01,10,11, waits SETTLE_CYCLES after each change,
// samples the 7 gate outputs and accumulates per-gate mismatch flags.
// Optional feature macro: GATE_TESTER_FIRST_FAIL_EN adds first_fail_valid and
// first_fail_idx, which capture the first vector of a run that mismatched.
module gate_lab_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       stim_a,
  output logic       stim_b,
  input  logic [6:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_vec,
  output logic [2:0] fail_count
`ifdef GATE_TESTER_FIRST_FAIL_EN
  ,
  output logic       first_fail_valid,
  output logic [1:0] first_fail_idx
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // SETTLE lasts SETTLE_CYCLES cycles, so the counter is loaded with one less;
  // the zero-settle build never enters SETTLE, so its load value is unused.
  localparam int SETTLE_LOAD_INT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_LOAD_INT);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       stim_q, stim_d;
  logic             pass_q, pass_d;
  logic [6:0]       fail_vec_q, fail_vec_d;
  logic [2:0]       fail_count_q, fail_count_d;
  logic [6:0]       mism;
`ifdef GATE_TESTER_FIRST_FAIL_EN
  logic             ff_valid_q, ff_valid_d;
  logic [1:0]       ff_idx_q, ff_idx_d;
`endif

  // Golden truth table, bit 6..0 = xnor, xor, nor, nand, not a, or, and.
  function automatic logic [6:0] expected_gates(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  // Next-state and result bookkeeping for the test sequence.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    stim_d       = stim_q;
    pass_d       = pass_q;
    fail_vec_d   = fail_vec_q;
    fail_count_d = fail_count_q;
`ifdef GATE_TESTER_FIRST_FAIL_EN
    ff_valid_d   = ff_valid_q;
    ff_idx_d     = ff_idx_q;
`endif
    mism = dut_out ^ expected_gates(idx_q[1], idx_q[0]);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fail_vec_d   = 7'd0;
          fail_count_d = 3'd0;
          pass_d       = 1'b0;
          idx_d        = 2'd0;
`ifdef GATE_TESTER_FIRST_FAIL_EN
          ff_valid_d   = 1'b0;
          ff_idx_d     = 2'd0;
`endif
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        stim_d  = idx_q;
        cnt_d   = SETTLE_LOAD;
        state_d = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        fail_vec_d = fail_vec_q | mism;
        if (|mism) begin
          fail_count_d = fail_count_q + 3'd1;
        end
`ifdef GATE_TESTER_FIRST_FAIL_EN
        if ((|mism) && !ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_idx_d   = idx_q;
        end
`endif
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        pass_d  = (fail_vec_q == 7'd0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      stim_q       <= 2'd0;
      pass_q       <= 1'b0;
      fail_vec_q   <= 7'd0;
      fail_count_q <= 3'd0;
`ifdef GATE_TESTER_FIRST_FAIL_EN
      ff_valid_q   <= 1'b0;
      ff_idx_q     <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      pass_q       <= pass_d;
      fail_vec_q   <= fail_vec_d;
      fail_count_q <= fail_count_d;
`ifdef GATE_TESTER_FIRST_FAIL_EN
      ff_valid_q   <= ff_valid_d;
      ff_idx_q     <= ff_idx_d;
`endif
    end
  end

  assign stim_a     = stim_q[1];
  assign stim_b     = stim_q[0];
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign fail_vec   = fail_vec_q;
  assign fail_count = fail_count_q;
`ifdef GATE_TESTER_FIRST_FAIL_EN
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
`endif

endmodule

// File: tb/tb_gate_lab_tester.sv
// Testbench for gate_lab_tester: a behavioural gate block with injectable
// corruption/stuck-at faults feeds the tester; a high-level reference model
// predicts the run results. A second instance checks the zero-settle build.
module tb_gate_lab_tester;

  localparam int SETTLE = 2;
  localparam int PER    = SETTLE + 2;
  localparam int RUNLEN = 4 * PER;

  logic       clk = 1'b0;
  logic       rstN;
  logic       startMain, startZero;
  logic       stimA, stimB, busy, done, pass;
  logic [6:0] failVec, dutOut;
  logic [2:0] failCount;
  logic       stimA0, stimB0, busy0, done0, pass0;
  logic [6:0] failVec0, dutOut0;
  logic [2:0] failCount0;
  logic [6:0] corrupt [4];
  logic [6:0] stuck0, stuck1;
  int         checks   = 0;
  int         failures = 0;
`ifdef GATE_TESTER_FIRST_FAIL_EN
  logic       firstFailValid, firstFailValid0;
  logic [1:0] firstFailIdx, firstFailIdx0;
`endif

  always #5 clk = ~clk;

  // Gate truth computed arithmetically from the input values.
  function automatic logic [6:0] goldGates(input logic a, input logic b);
    int ia, ib, sum, prod;
    ia = int'(a);
    ib = int'(b);
    sum = ia + ib;
    prod = ia * ib;
    return {(sum % 2) == 0, (sum % 2) == 1, sum == 0, prod == 0,
            ia == 0, sum > 0, prod == 1};
  endfunction

  assign dutOut  = ((goldGates(stimA, stimB) ^ corrupt[{stimA, stimB}]) & ~stuck0) | stuck1;
  assign dutOut0 = goldGates(stimA0, stimB0);

  gate_lab_tester #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dutMain (
    .clk(clk), .rst_n(rstN), .start(startMain),
    .stim_a(stimA), .stim_b(stimB), .dut_out(dutOut),
    .busy(busy), .done(done), .pass(pass),
    .fail_vec(failVec), .fail_count(failCount)
`ifdef GATE_TESTER_FIRST_FAIL_EN
    , .first_fail_valid(firstFailValid), .first_fail_idx(firstFailIdx)
`endif
  );

  gate_lab_tester #(.SETTLE_CYCLES(0), .CNT_W(4)) dutZero (
    .clk(clk), .rst_n(rstN), .start(startZero),
    .stim_a(stimA0), .stim_b(stimB0), .dut_out(dutOut0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_vec(failVec0), .fail_count(failCount0)
`ifdef GATE_TESTER_FIRST_FAIL_EN
    , .first_fail_valid(firstFailValid0), .first_fail_idx(firstFailIdx0)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what a full run over the four vectors should report.
  task automatic computeExpect(output logic [6:0] eFv, output logic [2:0] eCnt,
                               output logic ePass, output logic eFfv, output logic [1:0] eFfi);
    logic [6:0] g, obs, m;
    int cnt;
    eFv = 7'd0; cnt = 0; eFfv = 1'b0; eFfi = 2'd0;
    for (int i = 0; i < 4; i++) begin
      g   = goldGates(logic'(i / 2), logic'(i % 2));
      obs = ((g ^ corrupt[i]) & ~stuck0) | stuck1;
      m   = obs ^ g;
      eFv = eFv | m;
      if (m != 7'd0) begin
        cnt++;
        if (!eFfv) begin
          eFfv = 1'b1;
          eFfi = 2'(i);
        end
      end
    end
    eCnt  = 3'(cnt);
    ePass = (eFv == 7'd0);
  endtask

  // One complete run on the main instance; optional extra start pulses at
  // cycle t+6 and in the DONE cycle must be ignored.
  task automatic applyStimulus(input bit rePulse);
    logic [6:0] eFv;
    logic [2:0] eCnt;
    logic ePass, eFfv;
    logic [1:0] eFfi;
    int doneCount;
    doneCount = 0;
    computeExpect(eFv, eCnt, ePass, eFfv, eFfi);
    startMain = 1'b1;
    @(posedge clk); #1;
    startMain = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_clears_pass", pass, 0);
    checkOutput("start_clears_fv", failVec, 0);
    checkOutput("start_clears_cnt", failCount, 0);
`ifdef GATE_TESTER_FIRST_FAIL_EN
    checkOutput("start_clears_ffv", firstFailValid, 0);
`endif
    for (int n = 0; n <= RUNLEN + 1; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      startMain = rePulse && (n == 5 || n == RUNLEN);
      if (done) doneCount++;
      if (n == RUNLEN) checkOutput("done_latency", done, 1);
      if ((n % PER) == SETTLE + 1 && n < RUNLEN)
        checkOutput("stim_order", {stimA, stimB}, n / PER);
    end
    startMain = 1'b0;
    checkOutput("idle_busy", busy, 0);
    checkOutput("done_pulses", doneCount, 1);
    checkOutput("run_fail_vec", failVec, eFv);
    checkOutput("run_fail_count", failCount, eCnt);
    checkOutput("run_pass", pass, ePass);
`ifdef GATE_TESTER_FIRST_FAIL_EN
    checkOutput("run_ff_valid", firstFailValid, eFfv);
    if (eFfv) checkOutput("run_ff_idx", firstFailIdx, eFfi);
`endif
  endtask

  initial begin
    int doneAt;
    bit seen;
    rstN = 1'b0; startMain = 1'b0; startZero = 1'b0;
    stuck0 = 7'd0; stuck1 = 7'd0;
    for (int i = 0; i < 4; i++) corrupt[i] = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stim", {stimA, stimB}, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_fv", failVec, 0);
    checkOutput("reset_cnt", failCount, 0);
    @(negedge clk); rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] golden run");
    applyStimulus(1'b0);

    $display("[TB] xor output stuck at 0");
    stuck0 = 7'b0100000;
    applyStimulus(1'b0);
    checkOutput("stuck5_fv", failVec, 7'b0100000);
    checkOutput("stuck5_cnt", failCount, 2);
    checkOutput("stuck5_pass", pass, 0);
    stuck0 = 7'd0;

    $display("[TB] start re-pulsed during run and DONE");
    applyStimulus(1'b1);

    $display("[TB] randomized corruption runs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++)
        corrupt[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      applyStimulus(1'b0);
    end

    $display("[TB] reset during SETTLE of vector 2");
    for (int i = 0; i < 4; i++) corrupt[i] = 7'd0;
    corrupt[0] = 7'h7F;
    startMain = 1'b1;
    @(posedge clk); #1;
    startMain = 1'b0;
    repeat (2 * PER + 1) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_busy", busy, 1);
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_stim", {stimA, stimB}, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_fv", failVec, 0);
    checkOutput("async_rst_cnt", failCount, 0);
    checkOutput("async_rst_pass", pass, 0);
    @(negedge clk); rstN = 1'b1;
    @(posedge clk); #1;
    corrupt[0] = 7'd0;
    applyStimulus(1'b0);

`ifdef GATE_TESTER_FIRST_FAIL_EN
    $display("[TB] nand output stuck at 1");
    stuck1 = 7'b0001000;
    applyStimulus(1'b0);
    checkOutput("stuck3_fv", failVec, 7'b0001000);
    checkOutput("stuck3_cnt", failCount, 1);
    checkOutput("stuck3_ffv", firstFailValid, 1);
    checkOutput("stuck3_ffi", firstFailIdx, 3);
    stuck1 = 7'd0;
`endif

    $display("[TB] start held high");
    startMain = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= RUNLEN + 2; n++) begin
      @(posedge clk); #1;
      if (n == RUNLEN) checkOutput("held_done", done, 1);
      if (n == RUNLEN + 1) checkOutput("held_idle_gap", busy, 0);
      if (n == RUNLEN + 2) checkOutput("held_restart", busy, 1);
    end
    startMain = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4 * RUNLEN && !seen; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checkOutput("held_second_done", seen, 1);
    @(posedge clk); #1;
    checkOutput("held_second_pass", pass, 1);

    $display("[TB] zero settle build");
    startZero = 1'b1;
    @(posedge clk); #1;
    startZero = 1'b0;
    doneAt = -1;
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (done0 && doneAt < 0) doneAt = n;
    end
    checkOutput("zero_done_latency", doneAt, 8);
    checkOutput("zero_pass", pass0, 1);
    checkOutput("zero_fv", failVec0, 0);
    checkOutput("zero_cnt", failCount0, 0);
    checkOutput("zero_busy", busy0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
